interval_set_engine: RTL

Parametrised, stream-fed successor to the Day 5 range/ID core. Ranges arrive on a valid/ready channel instead of a byte ROM. Each range is sort-inserted into an internal table. The table is merged into disjoint intervals, and then a query stream is answered by binary search, with a per-query hit/index result on its own valid/ready channel. Value width, table depth and counter width are generic, so other interval puzzles can sit behind a shared ASCII-parser front end.

---
 rtl/interval_set_engine.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/interval_set_engine.sv
// interval_set_engine: stream-loaded sorted range table, interval merger
// and binary-search query responder with hit and coverage statistics.
module interval_set_engine #(
    parameter int VAL_W      = 64,
    parameter int MAX_RANGES = 256,
    parameter int IDX_W      = 8,
    parameter int CNT_W      = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             range_valid,
    output logic             range_ready,
    input  logic [VAL_W-1:0] range_lo,
    input  logic [VAL_W-1:0] range_hi,
    input  logic             range_last,
    input  logic             query_valid,
    output logic             query_ready,
    input  logic [VAL_W-1:0] query_val,
    input  logic             query_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_hit,
    output logic [IDX_W-1:0] res_idx,
    output logic [CNT_W-1:0] coverage,
    output logic [CNT_W-1:0] hit_count,
    output logic [IDX_W:0]   num_merged,
    output logic             overflow,
    output logic             done
);
    typedef enum logic [3:0] {
        S_LOAD, S_INSERT, S_MERGE, S_SAVE, S_QWAIT,
        S_ADDR, S_CMP, S_RESULT, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [VAL_W-1:0] raw_lo_q [MAX_RANGES];
    logic [VAL_W-1:0] raw_lo_d [MAX_RANGES];
    logic [VAL_W-1:0] raw_hi_q [MAX_RANGES];
    logic [VAL_W-1:0] raw_hi_d [MAX_RANGES];
    logic [VAL_W-1:0] mrg_lo_q [MAX_RANGES];
    logic [VAL_W-1:0] mrg_lo_d [MAX_RANGES];
    logic [VAL_W-1:0] mrg_hi_q [MAX_RANGES];
    logic [VAL_W-1:0] mrg_hi_d [MAX_RANGES];
    logic [IDX_W:0]   cnt_q, cnt_d, ptr_q, ptr_d, nm_q, nm_d;
    logic [IDX_W:0]   low_q, low_d, high_q, high_d;
    logic [IDX_W-1:0] mid_q, mid_d, res_idx_q, res_idx_d;
    logic [VAL_W-1:0] new_lo_q, new_lo_d, new_hi_q, new_hi_d;
    logic [VAL_W-1:0] cur_lo_q, cur_lo_d, cur_hi_q, cur_hi_d;
    logic [VAL_W-1:0] qval_q, qval_d;
    logic [VAL_W-1:0] rd_lo_q, rd_lo_d, rd_hi_q, rd_hi_d;
    logic [CNT_W-1:0] cov_q, cov_d, hits_q, hits_d;
    logic             new_last_q, new_last_d, qlast_q, qlast_d;
    logic             ovf_q, ovf_d, done_q, done_d;
    logic             res_valid_q, res_valid_d, res_hit_q, res_hit_d;
    logic             rng_rdy_q, rng_rdy_d, qry_rdy_q, qry_rdy_d;

    logic [IDX_W:0]   tgt;
    logic [IDX_W+1:0] sum;
    logic [IDX_W-1:0] mid_c, eidx;
    logic             joins, go_res, go_hit, rng_hs, qry_hs;

    always_comb begin
        state_d     = state_q;
        raw_lo_d    = raw_lo_q;
        raw_hi_d    = raw_hi_q;
        mrg_lo_d    = mrg_lo_q;
        mrg_hi_d    = mrg_hi_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        nm_d        = nm_q;
        low_d       = low_q;
        high_d      = high_q;
        mid_d       = mid_q;
        res_idx_d   = res_idx_q;
        new_lo_d    = new_lo_q;
        new_hi_d    = new_hi_q;
        new_last_d  = new_last_q;
        cur_lo_d    = cur_lo_q;
        cur_hi_d    = cur_hi_q;
        qval_d      = qval_q;
        qlast_d     = qlast_q;
        rd_lo_d     = rd_lo_q;
        rd_hi_d     = rd_hi_q;
        cov_d       = cov_q;
        hits_d      = hits_q;
        ovf_d       = ovf_q;
        done_d      = done_q;
        res_valid_d = res_valid_q;
        res_hit_d   = res_hit_q;
        go_res      = 1'b0;
        go_hit      = 1'b0;
        rng_hs      = range_valid & rng_rdy_q;
        qry_hs      = query_valid & qry_rdy_q;

        // First slot with a strictly greater lo keeps equal keys stable
        tgt = cnt_q;
        for (int i = MAX_RANGES - 1; i >= 0; i--) begin
            if (i < int'(cnt_q) && raw_lo_q[i] > new_lo_q) begin
                tgt = (IDX_W+1)'(i);
            end
        end

        sum   = {1'b0, low_q} + {1'b0, high_q};
        mid_c = sum[IDX_W:1];
        eidx  = ptr_q[IDX_W-1:0];
        joins = {1'b0, raw_lo_q[eidx]} <= ({1'b0, cur_hi_q} + (VAL_W+1)'(1));

        unique case (state_q)
            S_LOAD: begin
                ptr_d = '0;
                if (rng_hs) begin
                    new_lo_d   = range_lo;
                    new_hi_d   = range_hi;
                    new_last_d = range_last;
                    if (range_lo > range_hi) begin
                        state_d = range_last ? S_MERGE : S_LOAD;
                    end else if (cnt_q == (IDX_W+1)'(MAX_RANGES)) begin
                        ovf_d   = 1'b1;
                        state_d = range_last ? S_MERGE : S_LOAD;
                    end else begin
                        state_d = S_INSERT;
                    end
                end
            end
            S_INSERT: begin
                for (int i = 1; i < MAX_RANGES; i++) begin
                    if (i > int'(tgt) && i <= int'(cnt_q)) begin
                        raw_lo_d[i] = raw_lo_q[i-1];
                        raw_hi_d[i] = raw_hi_q[i-1];
                    end
                end
                raw_lo_d[tgt[IDX_W-1:0]] = new_lo_q;
                raw_hi_d[tgt[IDX_W-1:0]] = new_hi_q;
                cnt_d   = cnt_q + (IDX_W+1)'(1);
                state_d = new_last_q ? S_MERGE : S_LOAD;
            end
            S_MERGE: begin
                if (ptr_q == '0) begin
                    if (cnt_q == '0) begin
                        state_d = S_QWAIT;
                    end else begin
                        cur_lo_d = raw_lo_q[0];
                        cur_hi_d = raw_hi_q[0];
                        ptr_d    = (IDX_W+1)'(1);
                    end
                end else if (ptr_q == cnt_q || !joins) begin
                    state_d = S_SAVE;
                end else begin
                    if (raw_hi_q[eidx] > cur_hi_q) cur_hi_d = raw_hi_q[eidx];
                    ptr_d = ptr_q + (IDX_W+1)'(1);
                end
            end
            S_SAVE: begin
                mrg_lo_d[nm_q[IDX_W-1:0]] = cur_lo_q;
                mrg_hi_d[nm_q[IDX_W-1:0]] = cur_hi_q;
                nm_d  = nm_q + (IDX_W+1)'(1);
                cov_d = cov_q + CNT_W'(cur_hi_q - cur_lo_q) + CNT_W'(1);
                if (ptr_q == cnt_q) begin
                    state_d = S_QWAIT;
                end else begin
                    cur_lo_d = raw_lo_q[eidx];
                    cur_hi_d = raw_hi_q[eidx];
                    ptr_d    = ptr_q + (IDX_W+1)'(1);
                    state_d  = S_MERGE;
                end
            end
            S_QWAIT: begin
                if (qry_hs) begin
                    qval_d  = query_val;
                    qlast_d = query_last;
                    low_d   = '0;
                    if (nm_q == '0) begin
                        go_res = 1'b1;
                    end else begin
                        high_d  = nm_q - (IDX_W+1)'(1);
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (low_q > high_q) begin
                    go_res = 1'b1;
                end else begin
                    mid_d   = mid_c;
                    rd_lo_d = mrg_lo_q[mid_c];
                    rd_hi_d = mrg_hi_q[mid_c];
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (qval_q >= rd_lo_q && qval_q <= rd_hi_q) begin
                    go_res = 1'b1;
                    go_hit = 1'b1;
                end else if (qval_q < rd_lo_q) begin
                    // mid==0 would underflow high; that is already a miss
                    if (mid_q == '0) begin
                        go_res = 1'b1;
                    end else begin
                        high_d  = {1'b0, mid_q} - (IDX_W+1)'(1);
                        state_d = S_ADDR;
                    end
                end else begin
                    low_d   = {1'b0, mid_q} + (IDX_W+1)'(1);
                    state_d = S_ADDR;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    done_d      = qlast_q;
                    state_d     = qlast_q ? S_DONE : S_QWAIT;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        if (go_res) begin
            state_d     = S_RESULT;
            res_valid_d = 1'b1;
            res_hit_d   = go_hit;
            res_idx_d   = go_hit ? mid_q : '0;
            if (go_hit) hits_d = hits_q + CNT_W'(1);
        end
        rng_rdy_d = (state_d == S_LOAD);
        qry_rdy_d = (state_d == S_QWAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            ptr_q       <= '0;
            nm_q        <= '0;
            low_q       <= '0;
            high_q      <= '0;
            mid_q       <= '0;
            res_idx_q   <= '0;
            new_lo_q    <= '0;
            new_hi_q    <= '0;
            new_last_q  <= 1'b0;
            cur_lo_q    <= '0;
            cur_hi_q    <= '0;
            qval_q      <= '0;
            qlast_q     <= 1'b0;
            rd_lo_q     <= '0;
            rd_hi_q     <= '0;
            cov_q       <= '0;
            hits_q      <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_hit_q   <= 1'b0;
            rng_rdy_q   <= 1'b0;
            qry_rdy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            raw_lo_q    <= raw_lo_d;
            raw_hi_q    <= raw_hi_d;
            mrg_lo_q    <= mrg_lo_d;
            mrg_hi_q    <= mrg_hi_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            nm_q        <= nm_d;
            low_q       <= low_d;
            high_q      <= high_d;
            mid_q       <= mid_d;
            res_idx_q   <= res_idx_d;
            new_lo_q    <= new_lo_d;
            new_hi_q    <= new_hi_d;
            new_last_q  <= new_last_d;
            cur_lo_q    <= cur_lo_d;
            cur_hi_q    <= cur_hi_d;
            qval_q      <= qval_d;
            qlast_q     <= qlast_d;
            rd_lo_q     <= rd_lo_d;
            rd_hi_q     <= rd_hi_d;
            cov_q       <= cov_d;
            hits_q      <= hits_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_hit_q   <= res_hit_d;
            rng_rdy_q   <= rng_rdy_d;
            qry_rdy_q   <= qry_rdy_d;
        end
    end

    assign range_ready = rng_rdy_q;
    assign query_ready = qry_rdy_q;
    assign res_valid   = res_valid_q;
    assign res_hit     = res_hit_q;
    assign res_idx     = res_idx_q;
    assign coverage    = cov_q;
    assign hit_count   = hits_q;
    assign num_merged  = nm_q;
    assign overflow    = ovf_q;
    assign done        = done_q;
endmodule
